alu_arbiter: RTL and testbench

- Shares the single execute-stage ALU between two requesters: port 0 (main EX pipeline op) and port 1 (auxiliary address/branch-compare unit).
- Round-robin grant per cycle; drives the ALU's ALUControl/SrcA/SrcB; captures the ALU's combinational Result/Zero into a per-port response register.
- Sits between the ID/EX pipeline register and the ALU, downstream of alu_decoder.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/rr_arb2.sv | 13 +
 rtl/alu_arbiter.sv | 47 ++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes and port indices shared by the ALU arbiter slice
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_IDLE_CTRL = ALU_ADD;
    localparam int P_EX = 0;
    localparam int P_AUX = 1;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two-port request/response bus between requesters and the ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CTRL_W = 3
);
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [CTRL_W-1:0] req_ctrl0;
    logic [CTRL_W-1:0] req_ctrl1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [WIDTH-1:0] rsp_data0;
    logic [WIDTH-1:0] rsp_data1;
    logic [1:0] rsp_zero;
    modport master (
        output req_valid, req_ctrl0, req_ctrl1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_zero
    );
    modport slave (
        input req_valid, req_ctrl0, req_ctrl1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_zero
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; pointer flips to the other port after each grant
module rr_arb2 (
    input logic clk,
    input logic rst,
    input logic [1:0] elig,
    output logic [1:0] grant
);
    logic rr_ptr;
    always_comb grant = (&elig) ? (rr_ptr ? 2'b10 : 2'b01) : elig;
    always_ff @(posedge clk)
        if (!rst) rr_ptr <= 1'b0;
        else if (|grant) rr_ptr <= grant[0];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two ports with round-robin grant and per-port response slots
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTRL_W = 3
) (
    input logic clk,
    input logic rst,
    alu_arbiter_if.slave bus,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input logic [WIDTH-1:0] alu_result,
    input logic alu_zero
);
    logic [1:0] elig;
    logic [1:0] grant;
    // a port may issue only while its slot is empty or being drained this cycle
    assign elig = {2{rst}} & bus.req_valid & (~bus.rsp_valid | bus.rsp_ready);
    rr_arb2 u_rr (.clk(clk), .rst(rst), .elig(elig), .grant(grant));
    assign bus.req_ready = grant;
    always_comb begin
        alu_ctrl = grant[P_AUX] ? bus.req_ctrl1 : grant[P_EX] ? bus.req_ctrl0 : CTRL_W'(ALU_IDLE_CTRL);
        alu_a = grant[P_AUX] ? bus.req_a1 : grant[P_EX] ? bus.req_a0 : '0;
        alu_b = grant[P_AUX] ? bus.req_b1 : grant[P_EX] ? bus.req_b0 : '0;
    end
    for (genvar i = 0; i < 2; i++) begin : g_slot
        logic v;
        logic z;
        logic [WIDTH-1:0] d;
        always_ff @(posedge clk)
            if (!rst) begin
                v <= 1'b0;
                z <= 1'b0;
                d <= '0;
            end else if (grant[i]) begin
                v <= 1'b1;
                z <= alu_zero;
                d <= alu_result;
            end else if (bus.rsp_ready[i]) v <= 1'b0;
        assign bus.rsp_valid[i] = v;
        assign bus.rsp_zero[i] = z;
    end
    assign bus.rsp_data0 = g_slot[0].d;
    assign bus.rsp_data1 = g_slot[1].d;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural ALU and a reference arbitration model
module tb_alu_arbiter;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic alu_zero;
    int total = 0;
    int bad = 0;
    int m_ptr = 0;
    logic [1:0] m_valid = 2'b00;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    alu_arbiter_if #(.WIDTH(32), .CTRL_W(3)) bus ();
    alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] alu_f(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR: return a | b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction
    assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
    assign alu_zero = (alu_result == 32'd0);
    // one clock: inputs are set at the negedge before the call; returns at the next negedge
    task automatic step();
        logic [1:0] el, g;
        logic [2:0] ec;
        logic [31:0] ea, eb, r;
        #1;
        el = rst ? (bus.req_valid & (~m_valid | bus.rsp_ready)) : 2'b00;
        g = (el == 2'b11) ? (m_ptr != 0 ? 2'b10 : 2'b01) : el;
        total++;
        if (bus.req_ready !== g) begin
            bad++;
            $display("FAIL req_ready got=%b exp=%b t=%0t", bus.req_ready, g, $time);
        end
        ec = g[1] ? bus.req_ctrl1 : g[0] ? bus.req_ctrl0 : ALU_IDLE_CTRL;
        ea = g[1] ? bus.req_a1 : g[0] ? bus.req_a0 : 32'd0;
        eb = g[1] ? bus.req_b1 : g[0] ? bus.req_b0 : 32'd0;
        total++;
        if ({alu_ctrl, alu_a, alu_b} !== {ec, ea, eb}) begin
            bad++;
            $display("FAIL alu_drive got=%h/%h/%h exp=%h/%h/%h", alu_ctrl, alu_a, alu_b, ec, ea, eb);
        end
        if (rst) begin
            if (m_valid[0] && bus.rsp_ready[0]) void'(q0.pop_front());
            if (m_valid[1] && bus.rsp_ready[1]) void'(q1.pop_front());
            if (g[0]) begin
                r = alu_f(bus.req_ctrl0, bus.req_a0, bus.req_b0);
                q0.push_back({r == 32'd0, r});
            end
            if (g[1]) begin
                r = alu_f(bus.req_ctrl1, bus.req_a1, bus.req_b1);
                q1.push_back({r == 32'd0, r});
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            m_valid = 2'b00;
            m_ptr = 0;
            q0.delete();
            q1.delete();
        end else begin
            for (int n = 0; n < 2; n++)
                if (g[n]) m_valid[n] = 1'b1;
                else if (bus.rsp_ready[n]) m_valid[n] = 1'b0;
            if (g != 2'b00) m_ptr = g[0] ? 1 : 0;
        end
        total++;
        if (bus.rsp_valid !== m_valid) begin
            bad++;
            $display("FAIL rsp_valid got=%b exp=%b t=%0t", bus.rsp_valid, m_valid, $time);
        end
        if (m_valid[0]) begin
            total++;
            if (q0.size() == 0 || {bus.rsp_zero[0], bus.rsp_data0} !== q0[0]) begin
                bad++;
                $display("FAIL rsp0 got=%h exp=%h", {bus.rsp_zero[0], bus.rsp_data0}, q0.size() ? q0[0] : 33'hx);
            end
        end
        if (m_valid[1]) begin
            total++;
            if (q1.size() == 0 || {bus.rsp_zero[1], bus.rsp_data1} !== q1[0]) begin
                bad++;
                $display("FAIL rsp1 got=%h exp=%h", {bus.rsp_zero[1], bus.rsp_data1}, q1.size() ? q1[0] : 33'hx);
            end
        end
        @(negedge clk);
    endtask
    task automatic set_req(logic [1:0] v, logic [1:0] rr);
        bus.req_valid = v;
        bus.rsp_ready = rr;
        bus.req_ctrl0 = 3'($urandom_range(0, 7));
        bus.req_ctrl1 = 3'($urandom_range(0, 7));
        bus.req_a0 = $urandom;
        bus.req_a1 = $urandom;
        bus.req_b0 = $urandom;
        bus.req_b1 = $urandom;
    endtask
    task automatic test_reset();
        rst = 1'b0;
        set_req(2'b11, 2'b11);
        step();
        step();
        total++;
        if ({bus.rsp_zero, bus.rsp_data0, bus.rsp_data1} !== 66'd0) begin
            bad++;
            $display("FAIL reset_regs got=%h exp=0", {bus.rsp_zero, bus.rsp_data0, bus.rsp_data1});
        end
        rst = 1'b1;
        set_req(2'b11, 2'b11);
        step();
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_single();
        set_req(2'b01, 2'b11);
        bus.req_ctrl0 = ALU_ADD;
        bus.req_a0 = 32'd5;
        bus.req_b0 = 32'd7;
        step();
        total++;
        if ({bus.rsp_valid[0], bus.rsp_zero[0], bus.rsp_data0} !== {1'b1, 1'b0, 32'd12}) begin
            bad++;
            $display("FAIL single got=%b/%b/%0d exp=1/0/12", bus.rsp_valid[0], bus.rsp_zero[0], bus.rsp_data0);
        end
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_contention();
        for (int k = 0; k < 8; k++) begin
            set_req(2'b11, 2'b11);
            step();
        end
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_backpressure();
        logic [31:0] held;
        set_req(2'b10, 2'b00);
        step();
        held = bus.rsp_data1;
        for (int k = 0; k < 4; k++) begin
            set_req(2'b11, 2'b01);
            step();
            total++;
            if (bus.rsp_data1 !== held || bus.rsp_valid[1] !== 1'b1) begin
                bad++;
                $display("FAIL hold1 got=%h/%b exp=%h/1", bus.rsp_data1, bus.rsp_valid[1], held);
            end
        end
        set_req(2'b11, 2'b11);
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin
            bad++;
            $display("FAIL release1 got=%b exp=10", bus.req_ready);
        end
        step();
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_zero_sub();
        set_req(2'b10, 2'b11);
        bus.req_ctrl1 = ALU_SUB;
        bus.req_a1 = 32'h1234;
        bus.req_b1 = 32'h1234;
        step();
        total++;
        if ({bus.rsp_zero[1], bus.rsp_data1} !== {1'b1, 32'd0}) begin
            bad++;
            $display("FAIL zero_sub got=%b/%h exp=1/0", bus.rsp_zero[1], bus.rsp_data1);
        end
        set_req(2'b01, 2'b11);
        bus.req_ctrl0 = 3'b111;
        step();
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            set_req(2'b01, 2'b11);
            step();
        end
        set_req(2'b00, 2'b11);
        step();
    endtask
    task automatic test_reset_mid();
        set_req(2'b01, 2'b00);
        step();
        rst = 1'b0;
        set_req(2'b00, 2'b00);
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(2'b00, 2'b00);
            step();
        end
        total++;
        if (bus.rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=00", bus.rsp_valid);
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_zero_sub();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
